// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the two ALU requesters, the shared combinational ALU,
// the response consumer and alu_share_arbiter.
// The master modport is the environment side (issue logic, ALU, consumer).
// The slave modport is the arbiter side.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    // Requester 0: main execute stage
    logic              req0_valid;
    logic              req0_ready;
    logic [4:0]        req0_opcode;
    logic [2:0]        req0_func3;
    logic              req0_func7;
    logic [DATA_W-1:0] req0_op1;
    logic [DATA_W-1:0] req0_op2;
    logic [TAG_W-1:0]  req0_tag;

    // Requester 1: address/branch-resolution helper
    logic              req1_valid;
    logic              req1_ready;
    logic [4:0]        req1_opcode;
    logic [2:0]        req1_func3;
    logic              req1_func7;
    logic [DATA_W-1:0] req1_op1;
    logic [DATA_W-1:0] req1_op2;
    logic [TAG_W-1:0]  req1_tag;

    // Shared ALU
    logic [4:0]        alu_opcode;
    logic [2:0]        alu_func3;
    logic              alu_func7;
    logic [DATA_W-1:0] alu_operand1;
    logic [DATA_W-1:0] alu_operand2;
    logic [DATA_W-1:0] alu_result;

    // Response slot
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req0_valid, req0_opcode, req0_func3, req0_func7,
               req0_op1, req0_op2, req0_tag,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_func3, req1_func7,
               req1_op1, req1_op2, req1_tag,
        input  req1_ready,
        input  alu_opcode, alu_func3, alu_func7, alu_operand1, alu_operand2,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_tag, rsp_data,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_func3, req0_func7,
               req0_op1, req0_op2, req0_tag,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_func3, req1_func7,
               req1_op1, req1_op2, req1_tag,
        output req1_ready,
        output alu_opcode, alu_func3, alu_func7, alu_operand1, alu_operand2,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_tag, rsp_data,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational integer ALU between the execute
// stage (requester 0) and the address/branch helper (requester 1).
// The winning request drives the ALU in the cycle it fires. The ALU result is
// captured into a one-entry response slot, together with the requester id
// and tag.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win
// contention. In that build the round-robin pointer does not exist.
// The default build uses round-robin.
module alu_share_arbiter #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              any_valid;
    logic              slot_avail;
    logic              fire;
    logic              sel;

    logic [4:0]        sel_opcode;
    logic [2:0]        sel_func3;
    logic              sel_func7;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;
    logic [TAG_W-1:0]  sel_tag;

    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_id_q;
    logic [TAG_W-1:0]  rsp_tag_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              last_gnt_q;
`endif

    assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 is picked only when requester 0 is idle.
    always_comb begin
        sel = 1'b0;
        if (!bus.req0_valid) begin
            sel = 1'b1;
        end
    end
`else
    // Round-robin: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        sel = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            sel = ~last_gnt_q;
        end
    end
`endif

    // Slot control: accept when empty or being drained, move to FULL on fire, EMPTY on drain.
    always_comb begin
        state_d        = state_q;
        slot_avail     = (state_q == EMPTY) || bus.rsp_ready;
        fire           = rst_n && slot_avail && any_valid;
        bus.req0_ready = fire && (sel == 1'b0);
        bus.req1_ready = fire && (sel == 1'b1);
        if (fire) begin
            state_d = FULL;
        end else if ((state_q == FULL) && bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // Payload of the currently selected requester.
    always_comb begin
        sel_opcode = bus.req0_opcode;
        sel_func3  = bus.req0_func3;
        sel_func7  = bus.req0_func7;
        sel_op1    = bus.req0_op1;
        sel_op2    = bus.req0_op2;
        sel_tag    = bus.req0_tag;
        if (sel) begin
            sel_opcode = bus.req1_opcode;
            sel_func3  = bus.req1_func3;
            sel_func7  = bus.req1_func7;
            sel_op1    = bus.req1_op1;
            sel_op2    = bus.req1_op2;
            sel_tag    = bus.req1_tag;
        end
    end

    // ALU sees the granted operation only while it fires, otherwise all zeros.
    always_comb begin
        bus.alu_opcode   = 5'b00000;
        bus.alu_func3    = 3'b000;
        bus.alu_func7    = 1'b0;
        bus.alu_operand1 = '0;
        bus.alu_operand2 = '0;
        if (fire) begin
            bus.alu_opcode   = sel_opcode;
            bus.alu_func3    = sel_func3;
            bus.alu_func7    = sel_func7;
            bus.alu_operand1 = sel_op1;
            bus.alu_operand2 = sel_op2;
        end
    end

    // Slot occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Remember who was served last; reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else if (fire) begin
            last_gnt_q <= sel;
        end
    end
`endif

    // Response slot contents: written only on fire, held across drain and stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_tag_q  <= '0;
        end else if (fire) begin
            rsp_data_q <= bus.alu_result;
            rsp_id_q   <= sel;
            rsp_tag_q  <= sel_tag;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter. It provides a small combinational
// reference ALU and checks the handshake, the ALU drive, the response slot
// and reset.
// Build option: ALU_ARB_FIXED_PRIO_EN changes the expected contention order.
module tb_alu_share_arbiter;

    localparam int DATA_W = 64;
    localparam int TAG_W  = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   k0;
    int   k1;
    int   g;

    alu_share_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    alu_share_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU covering ADD/SUB, ADDI-form and ADDW/SUBW.
    function automatic logic [63:0] aluModel(input logic [4:0] opc, input logic [2:0] f3,
                                             input logic f7, input logic [63:0] a,
                                             input logic [63:0] b);
        logic [31:0] w;
        logic [63:0] r;
        r = '0;
        w = '0;
        case (opc)
            5'b01100: if (f3 == 3'b000) r = f7 ? (a - b) : (a + b);
            5'b00100: if (f3 == 3'b000) r = a + b;
            5'b01110: if (f3 == 3'b000) begin
                w = f7 ? (a[31:0] - b[31:0]) : (a[31:0] + b[31:0]);
                r = {{32{w[31]}}, w};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // The ALU is purely combinational on the arbiter's drive.
    always_comb begin
        bus.alu_result = aluModel(bus.alu_opcode, bus.alu_func3, bus.alu_func7,
                                  bus.alu_operand1, bus.alu_operand2);
    end

    task automatic applyStimulus(input int which, input logic valid, input logic [4:0] opc,
                                 input logic [2:0] f3, input logic f7, input logic [63:0] a,
                                 input logic [63:0] b, input logic [3:0] tag);
        if (which == 0) begin
            bus.req0_valid  = valid;
            bus.req0_opcode = opc;
            bus.req0_func3  = f3;
            bus.req0_func7  = f7;
            bus.req0_op1    = a;
            bus.req0_op2    = b;
            bus.req0_tag    = tag;
        end else begin
            bus.req1_valid  = valid;
            bus.req1_opcode = opc;
            bus.req1_func3  = f3;
            bus.req1_func7  = f7;
            bus.req1_op1    = a;
            bus.req1_op2    = b;
            bus.req1_tag    = tag;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        k0     = 0;
        k1     = 0;
        g      = 0;
        bus.rsp_ready = 1'b0;
        applyStimulus(0, 1'b0, 5'd0, 3'd0, 1'b0, 64'd0, 64'd0, 4'd0);
        applyStimulus(1, 1'b0, 5'd0, 3'd0, 1'b0, 64'd0, 64'd0, 4'd0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state, with a request already valid
        applyStimulus(0, 1'b1, 5'b01100, 3'd0, 1'b0, 64'd5, 64'd7, 4'd3);
        #1;
        $display("[TB] reset checks");
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_rsp_data", bus.rsp_data, 64'd0);
        checkOutput("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        checkOutput("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        checkOutput("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
        checkOutput("rst_alu_opcode", 64'(bus.alu_opcode), 64'd0);
        checkOutput("rst_alu_operand1", bus.alu_operand1, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op: ADD 5+7 tag 3 from req0
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("single_req0_ready", 64'(bus.req0_ready), 64'd1);
        checkOutput("single_req1_ready", 64'(bus.req1_ready), 64'd0);
        checkOutput("single_alu_opcode", 64'(bus.alu_opcode), 64'h0C);
        checkOutput("single_alu_operand1", bus.alu_operand1, 64'd5);
        checkOutput("single_alu_operand2", bus.alu_operand2, 64'd7);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 3'd0, 1'b0, 64'd0, 64'd0, 4'd0);
        checkOutput("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        checkOutput("single_rsp_data", bus.rsp_data, 64'd12);
        checkOutput("single_rsp_id", 64'(bus.rsp_id), 64'd0);
        checkOutput("single_rsp_tag", 64'(bus.rsp_tag), 64'd3);
        #1;
        checkOutput("nofire_req0_ready", 64'(bus.req0_ready), 64'd0);
        checkOutput("nofire_alu_operand1", bus.alu_operand1, 64'd0);
        tick();
        checkOutput("drain_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("drain_rsp_data_hold", bus.rsp_data, 64'd12);
        checkOutput("drain_rsp_tag_hold", 64'(bus.rsp_tag), 64'd3);

        // Idle for 10 cycles
        $display("[TB] idle checks");
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_alu_opcode", 64'(bus.alu_opcode), 64'd0);
            checkOutput("idle_alu_operand1", bus.alu_operand1, 64'd0);
            checkOutput("idle_alu_operand2", bus.alu_operand2, 64'd0);
            checkOutput("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end

        // Pointer kept through idle: req0 was served last, so req1 wins now (RR)
        applyStimulus(0, 1'b1, 5'b01100, 3'd0, 1'b0, 64'd20, 64'd22, 4'd4);
        applyStimulus(1, 1'b1, 5'b01100, 3'd0, 1'b0, 64'd1, 64'd2, 4'd5);
        #1;
        checkOutput("ptr_req0_ready", 64'(bus.req0_ready), FIXED ? 64'd1 : 64'd0);
        checkOutput("ptr_req1_ready", 64'(bus.req1_ready), FIXED ? 64'd0 : 64'd1);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 3'd0, 1'b0, 64'd0, 64'd0, 4'd0);
        applyStimulus(1, 1'b0, 5'd0, 3'd0, 1'b0, 64'd0, 64'd0, 4'd0);
        bus.rsp_ready = 1'b0;
        checkOutput("ptr_rsp_id", 64'(bus.rsp_id), FIXED ? 64'd0 : 64'd1);
        checkOutput("ptr_rsp_data", bus.rsp_data, FIXED ? 64'd42 : 64'd3);
        checkOutput("ptr_rsp_tag", 64'(bus.rsp_tag), FIXED ? 64'd4 : 64'd5);

        // Asynchronous reset while FULL, away from any clock edge
        $display("[TB] async reset while full");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("arst_rsp_data", bus.rsp_data, 64'd0);
        checkOutput("arst_rsp_id", 64'(bus.rsp_id), 64'd0);
        checkOutput("arst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        checkOutput("arst_after_rsp_valid", 64'(bus.rsp_valid), 64'd0);

        // Contention for 4 ops after reset: req0 op1=100+k0 op2=1, req1 op1=200+k1 op2=2
        $display("[TB] contention");
        bus.rsp_ready = 1'b1;
        applyStimulus(0, 1'b1, 5'b01100, 3'd0, 1'b0, 64'(100 + k0), 64'd1, 4'(k0));
        applyStimulus(1, 1'b1, 5'b01100, 3'd0, 1'b0, 64'(200 + k1), 64'd2, 4'(8 + k1));
        for (int i = 0; i < 4; i++) begin
            g = FIXED ? 0 : (i % 2);
            #1;
            checkOutput("cont_req0_ready", 64'(bus.req0_ready), (g == 0) ? 64'd1 : 64'd0);
            checkOutput("cont_req1_ready", 64'(bus.req1_ready), (g == 1) ? 64'd1 : 64'd0);
            tick();
            checkOutput("cont_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("cont_rsp_id", 64'(bus.rsp_id), 64'(g));
            checkOutput("cont_rsp_data", bus.rsp_data, (g == 0) ? 64'(101 + k0) : 64'(202 + k1));
            checkOutput("cont_rsp_tag", 64'(bus.rsp_tag), (g == 0) ? 64'(k0) : 64'(8 + k1));
            if (g == 0) begin
                k0++;
                applyStimulus(0, 1'b1, 5'b01100, 3'd0, 1'b0, 64'(100 + k0), 64'd1, 4'(k0));
            end else begin
                k1++;
                applyStimulus(1, 1'b1, 5'b01100, 3'd0, 1'b0, 64'(200 + k1), 64'd2, 4'(8 + k1));
            end
        end
        applyStimulus(0, 1'b0, 5'd0, 3'd0, 1'b0, 64'd0, 64'd0, 4'd0);
        applyStimulus(1, 1'b0, 5'd0, 3'd0, 1'b0, 64'd0, 64'd0, 4'd0);
        tick();
        checkOutput("cont_drain_rsp_valid", 64'(bus.rsp_valid), 64'd0);

        // Backpressure: req1 SUBW 0-1 tag 7, then a pending req0 ADDI-form 0x10+0x20 tag 2
        $display("[TB] backpressure");
        bus.rsp_ready = 1'b0;
        applyStimulus(1, 1'b1, 5'b01110, 3'd0, 1'b1, 64'd0, 64'd1, 4'd7);
        #1;
        checkOutput("bp_req1_ready", 64'(bus.req1_ready), 64'd1);
        checkOutput("bp_alu_func7", 64'(bus.alu_func7), 64'd1);
        tick();
        applyStimulus(1, 1'b0, 5'd0, 3'd0, 1'b0, 64'd0, 64'd0, 4'd0);
        applyStimulus(0, 1'b1, 5'b00100, 3'd0, 1'b0, 64'h10, 64'h20, 4'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("bp_rsp_data", bus.rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
            checkOutput("bp_rsp_id", 64'(bus.rsp_id), 64'd1);
            checkOutput("bp_rsp_tag", 64'(bus.rsp_tag), 64'd7);
            checkOutput("bp_req0_ready", 64'(bus.req0_ready), 64'd0);
            checkOutput("bp_req1_ready", 64'(bus.req1_ready), 64'd0);
            checkOutput("bp_alu_operand1", bus.alu_operand1, 64'd0);
            tick();
        end

        // Release: drain and fire in the same cycle, no bubble
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("df_req0_ready", 64'(bus.req0_ready), 64'd1);
        checkOutput("df_alu_operand1", bus.alu_operand1, 64'h10);
        checkOutput("df_alu_opcode", 64'(bus.alu_opcode), 64'h04);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 3'd0, 1'b0, 64'd0, 64'd0, 4'd0);
        checkOutput("df_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        checkOutput("df_rsp_data", bus.rsp_data, 64'h30);
        checkOutput("df_rsp_id", 64'(bus.rsp_id), 64'd0);
        checkOutput("df_rsp_tag", 64'(bus.rsp_tag), 64'd2);
        tick();
        checkOutput("end_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("end_rsp_data_hold", bus.rsp_data, 64'h30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single integer ALU between two requesters: req0 is the main execute stage and req1 is the address/branch-resolution helper.
- Arbitrates requests with a valid/ready handshake and drives the ALU's opcode, func3, func7 and operand inputs combinationally from the granted request.
- Registers the ALU result into a one-entry response slot, returned with requester id and tag.
- Sits between the issue logic and the ALU; the ALU itself stays purely combinational.

Parameters:
- DATA_W, 64, operand/result width.
- TAG_W, 4, opaque requester tag width, returned unchanged with the response.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_opcode  in  5  instr[6:2] opcode field
- req0_func3  in  3  func3
- req0_func7  in  1  instr[30]
- req0_op1  in  DATA_W  operand1
- req0_op2  in  DATA_W  operand2
- req0_tag  in  TAG_W  tag
- req1_*  same set as req0_* for requester 1
- alu_opcode  out  5  to ALU
- alu_func3  out  3  to ALU
- alu_func7  out  1  to ALU
- alu_operand1  out  DATA_W  to ALU
- alu_operand2  out  DATA_W  to ALU
- alu_result  in  DATA_W  from ALU, combinational
- rsp_valid  out  1  response slot full
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  0 = req0, 1 = req1
- rsp_tag  out  TAG_W  tag of the completed operation
- rsp_data  out  DATA_W  registered ALU result

Behaviour:
- State machine, one bit: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- slot_avail = EMPTY or (FULL and rsp_ready).
- Round-robin pointer last_gnt (1 bit):
  - Only one requester valid: it is selected.
  - Both valid: select the requester != last_gnt.
- Handshake:
  - reqN_ready = slot_avail and reqN_valid and sel==N.
  - At most one ready is high per cycle.
  - Requesters must hold valid and payload stable until ready.
  - A requester's valid must not depend on its ready.
- Fire (reqN_valid and reqN_ready):
  - At the clock edge capture rsp_data<=alu_result, rsp_id<=N, rsp_tag<=reqN_tag.
  - State goes to FULL and last_gnt<=N.
- ALU drive:
  - During a fire, the alu_* outputs carry the selected request's fields unchanged.
  - In any other cycle they are driven to all zeros (opcode 5'b00000, operands 0); the result is ignored.
- Latency: 1 cycle from fire to rsp_valid.
- Throughput: 1 operation/cycle when rsp_ready is held high.
- Drain only (FULL, rsp_ready=1, no fire): go to EMPTY; rsp_data/rsp_id/rsp_tag hold their last values.
- Drain and fire in the same cycle: the slot is overwritten with the new result and stays FULL.
- Backpressure (FULL, rsp_ready=0):
  - Both readies are 0 and the slot holds.
  - Pending requests wait; last_gnt does not change.
- No valid requests: no state change, pointer unchanged.
- Reset (asynchronous, any time, including mid-transaction):
  - State EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_tag=0.
  - last_gnt=1, so req0 wins the first contention.
  - An in-flight response is discarded.
  - reqN_ready=0 and alu_*=0 while rst_n=0.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, req0 always wins contention. last_gnt is not implemented and req1 is granted only when req0_valid=0.
- Undefined: round-robin as above.

Test Plan:
- Single op: req0 opcode 01100, func3 000, func7 0, op1=5, op2=7, tag=3, rsp_ready=1. Expected: req0_ready high in cycle 0; in cycle 1 rsp_valid=1, rsp_data=12, rsp_id=0, rsp_tag=3.
- Contention: both requesters valid for 4 consecutive ops after reset, rsp_ready=1. Expected grant order 0,1,0,1 and responses in that order, one per cycle. With ALU_ARB_FIXED_PRIO_EN: 0,0,0,0 and req1 starves.
- Backpressure:
  - Setup: req1 SUBW (opcode 01110, func3 000, func7 1) with op1=0, op2=1, and rsp_ready=0 for 3 cycles.
  - During the stall: rsp_data stays 0xFFFFFFFFFFFFFFFF, both readies 0, and a pending req0 waits.
  - Release rsp_ready: req0 is granted that same cycle.
- Drain+fire: FULL with rsp_ready=1 and req0 valid (op1=0x10 ADDI-form opcode 00100, op2=0x20). Expected: the next cycle shows rsp_data=0x30 with no bubble cycle.
- Reset mid-op: assert rst_n=0 asynchronously while FULL. Expected: rsp_valid drops immediately without waiting for a clock edge. After release, the first contention grants req0.
- Idle: no valid for 10 cycles. Expected: alu_* stay 0, rsp_valid stays 0, pointer unchanged.
